// File: rtl/b_type.sv
// rtl/b_type.sv - RV32I conditional-branch resolution: compare, next PC, status flags, registered copy
module b_type (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [31:0] iaddr,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] pc,
    output logic        taken,
    output logic        illegal,
    output logic        misaligned,
    output logic [31:0] pc_q,
    output logic        taken_q
);

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } funct3_e;

    funct3_e     funct3;
    logic        eq;
    logic        lt_s;
    logic        lt_u;
    logic [31:0] target;
    logic [31:0] seq_pc;

    // Opcode and register fields are not decoded; the caller gates on opcode.
    logic        unused_instr_bits;
    assign unused_instr_bits = &{1'b0, instr[31:15], instr[11:0]};

    assign funct3 = funct3_e'(instr[14:12]);

    assign eq   = (rs1 == rs2);
    assign lt_s = ($signed(rs1) < $signed(rs2));
    assign lt_u = (rs1 < rs2);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = ~eq;
            F3_BLT:  taken = lt_s;
            F3_BGE:  taken = ~lt_s;
            F3_BLTU: taken = lt_u;
            F3_BGEU: taken = ~lt_u;
            default: illegal = 1'b1;
        endcase
    end

    // Both sums wrap modulo 2^32; imm bit 0 is passed through untouched.
    assign target = iaddr + imm;
    assign seq_pc = iaddr + 32'd4;
    assign pc     = taken ? target : seq_pc;

    assign misaligned = taken & (pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= 32'h0;
            taken_q <= 1'b0;
        end else begin
            pc_q    <= pc;
            taken_q <= taken;
        end
    end

endmodule

// File: tb/tb_b_type.sv
// tb/tb_b_type.sv - self-checking bench for b_type: directed vector table, random model, reset sequences
module tb_b_type;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [31:0] iaddr;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic        taken;
    logic        illegal;
    logic        misaligned;
    logic [31:0] pc_q;
    logic        taken_q;

    int n_checks;
    int n_fail;

    b_type dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .iaddr      (iaddr),
        .imm        (imm),
        .rs1        (rs1),
        .rs2        (rs2),
        .pc         (pc),
        .taken      (taken),
        .illegal    (illegal),
        .misaligned (misaligned),
        .pc_q       (pc_q),
        .taken_q    (taken_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] iaddr;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic        taken;
        logic        illegal;
        logic        mis;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: branch rule from funct3 evaluated on 64-bit integers.
    task automatic model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] base, input logic [31:0] off,
                         output logic [31:0] npc, output logic t, output logic il, output logic mis);
        longint sa, sb, ua, ub, sum;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        il = 1'b0;
        t  = 1'b0;
        case (f3)
            3'd0: t = (ua == ub);
            3'd1: t = (ua != ub);
            3'd4: t = (sa <  sb);
            3'd5: t = (sa >= sb);
            3'd6: t = (ua <  ub);
            3'd7: t = (ua >= ub);
            default: il = 1'b1;
        endcase
        sum = longint'({32'h0, base}) + (t ? longint'({32'h0, off}) : 64'd4);
        npc = sum[31:0];
        mis = t && ((sum % 4) != 0);
    endtask

    task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] base, input logic [31:0] off);
        logic [31:0] w;
        w = $urandom;
        w[14:12] = f3;
        instr = w;
        rs1   = a;
        rs2   = b;
        iaddr = base;
        imm   = off;
    endtask

    task automatic check_comb(input string tag, input logic [31:0] epc, input logic et,
                              input logic eil, input logic emis);
        check({tag, " pc"}, pc, epc);
        check({tag, " taken"}, {31'h0, taken}, {31'h0, et});
        check({tag, " illegal"}, {31'h0, illegal}, {31'h0, eil});
        check({tag, " misaligned"}, {31'h0, misaligned}, {31'h0, emis});
    endtask

    initial begin
        logic [31:0] epc;
        logic        et, eil, emis;
        logic [2:0]  f3;
        logic [31:0] a, b, base, off;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(3'd0, 32'd10, 32'd10, 32'h0, 32'hFF);

        vecs[0]  = '{3'd0, 32'h0, 32'hFF, 32'd10, 32'd10,       32'hFF, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{3'd0, 32'h0, 32'hFF, 32'd5,  32'd10,       32'h04, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'd1, 32'h0, 32'hFF, 32'd10, 32'd10,       32'h04, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'd1, 32'h0, 32'hFF, 32'd5,  32'd10,       32'hFF, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{3'd4, 32'h0, 32'hFF, 32'd10, 32'd15,       32'hFF, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{3'd4, 32'h0, 32'hFF, 32'd10, 32'hFFFFFFF1, 32'h04, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'd5, 32'h0, 32'hFF, 32'd10, 32'hFFFFFFF1, 32'hFF, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{3'd5, 32'h0, 32'hFF, 32'd10, 32'd15,       32'h04, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'd7, 32'h0, 32'hFF, 32'd10, 32'd5,        32'hFF, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{3'd6, 32'h0, 32'hFF, 32'd10, 32'd5,        32'h04, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{3'd6, 32'h0, 32'hFF, 32'd10, 32'hFFFFFFF1, 32'hFF, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{3'd2, 32'h0, 32'hFF, 32'd10, 32'd10,       32'h04, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{3'd3, 32'h0, 32'hFF, 32'd10, 32'd10,       32'h04, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{3'd0, 32'hFFFFFFFC, 32'hFF, 32'd5, 32'd10, 32'h00, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{3'd0, 32'hFFFFFFF0, 32'h20, 32'd7, 32'd7,  32'h10, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{3'd7, 32'h100, 32'hFFFFFFF8, 32'd3, 32'd3, 32'hF8, 1'b1, 1'b0, 1'b0};

        // Reset is held from time 0 and across clock edges.
        @(posedge clk);
        #1;
        check("reset pc_q", pc_q, 32'h0);
        check("reset taken_q", {31'h0, taken_q}, 32'h0);
        check_comb("in-reset comb", 32'hFF, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].f3, vecs[i].rs1, vecs[i].rs2, vecs[i].iaddr, vecs[i].imm);
            #1;
            check_comb($sformatf("vec%0d", i), vecs[i].pc, vecs[i].taken, vecs[i].illegal, vecs[i].mis);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d pc_q", i), pc_q, vecs[i].pc);
            check($sformatf("vec%0d taken_q", i), {31'h0, taken_q}, {31'h0, vecs[i].taken});
        end

        for (int i = 0; i < 300; i++) begin
            f3   = 3'($urandom_range(0, 7));
            a    = $urandom;
            b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) begin
                a = 32'($urandom_range(0, 8)) - 32'd4;
                b = 32'($urandom_range(0, 8)) - 32'd4;
            end
            base = $urandom;
            off  = $urandom;
            model(f3, a, b, base, off, epc, et, eil, emis);
            @(negedge clk);
            drive(f3, a, b, base, off);
            #1;
            check_comb($sformatf("rand%0d", i), epc, et, eil, emis);
            @(posedge clk);
            #1;
            check($sformatf("rand%0d pc_q", i), pc_q, epc);
            check($sformatf("rand%0d taken_q", i), {31'h0, taken_q}, {31'h0, et});
        end

        // Mid-run asynchronous reset, asserted away from any clock edge.
        @(negedge clk);
        drive(3'd1, 32'd5, 32'd10, 32'h0, 32'hFF);
        @(posedge clk);
        #2;
        check("pre-reset pc_q", pc_q, 32'hFF);
        rst_n = 1'b0;
        #1;
        check("async reset pc_q", pc_q, 32'h0);
        check("async reset taken_q", {31'h0, taken_q}, 32'h0);
        check_comb("reset comb", 32'hFF, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("released no edge pc_q", pc_q, 32'h0);
        @(posedge clk);
        #1;
        check("post-release pc_q", pc_q, 32'hFF);
        check("post-release taken_q", {31'h0, taken_q}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/b_type.md
# b_type

Branch-resolution unit for the RV32I B-type (conditional branch) instructions. It decodes funct3 from the instruction word, compares the two source-register values signed or unsigned, and produces the next program counter: branch target when taken, sequential PC + 4 otherwise. It sits between the register-file read stage and the PC-update logic. It also provides status flags and a registered copy of the result for the pipeline.

## Interface
- Parameters: none (datapath fixed at 32 bits).
- clk  input  1  system clock; registered outputs update on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- instr  input  32  instruction word; only funct3 = instr[14:12] is decoded.
- iaddr  input  32  PC of the branch instruction.
- imm  input  32  signed byte offset, already sign-extended by the decoder.
- rs1  input  32  signed value of source register 1.
- rs2  input  32  signed value of source register 2.
- pc  output  32  combinational next PC.
- taken  output  1  combinational branch-taken flag.
- illegal  output  1  combinational flag: funct3 is not a branch encoding.
- misaligned  output  1  combinational flag: taken and pc[1:0] != 0.
- pc_q  output  32  pc registered on clk.
- taken_q  output  1  taken registered on clk.

## Operation
- Decode funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- Conditions:
  - BEQ: rs1 == rs2.
  - BNE: rs1 != rs2.
  - BLT: rs1 < rs2, signed.
  - BGE: rs1 >= rs2, signed.
  - BLTU: rs1 < rs2, unsigned.
  - BGEU: rs1 >= rs2, unsigned.
- funct3 010 or 011: illegal = 1, taken = 0.
- pc = taken ? iaddr + imm : iaddr + 4.
- Addition is 32-bit modulo 2^32; carry is discarded and wrap-around is permitted.
- imm is used unmodified; bit 0 is not cleared.
- misaligned = taken & (pc[1:0] != 2'b00). It is informational only and does not alter pc.
- instr[6:0] (opcode) and all other instr bits are ignored. Gating on opcode is the caller's responsibility.

## Timing
- pc, taken, illegal and misaligned are purely combinational from instr, iaddr, imm, rs1 and rs2: zero-cycle latency, valid within the same delta/cycle.
- pc_q and taken_q capture pc and taken on every rising clk edge. No handshake, no enable.
- rst_n low: pc_q = 32'h0 and taken_q = 0 immediately, independent of clk.
- Combinational outputs are unaffected by rst_n.
- rst_n deassertion: registers resume capture at the next rising edge.
- No state machine. Simultaneous input changes settle combinationally with no ordering dependence.

## Test plan
All scenarios use iaddr = 0 and imm = 32'hFF unless stated.
- BEQ: rs1 = 10, rs2 = 10 -> pc = 32'h000000FF, taken = 1. Then rs1 = 5 -> pc = 32'h00000004, taken = 0.
- BNE: 10/10 -> pc = 32'h4. Then rs1 = 5 -> pc = 32'hFF, taken = 1.
- BLT/BGE signed:
  - BLT 10/15 -> 32'hFF.
  - BLT 10/-15 -> 32'h4.
  - BGE 10/-15 -> 32'hFF.
  - BGE 10/15 -> 32'h4.
- Unsigned:
  - BGEU 10/5 -> 32'hFF.
  - BLTU 10/5 -> 32'h4.
  - BLTU 10/-15 (0xFFFFFFF1) -> 32'hFF.
- Illegal/wrap:
  - funct3 = 010 -> illegal = 1, pc = 32'h4.
  - iaddr = 32'hFFFFFFFC, not taken -> pc = 32'h0.
  - Taken with imm = 32'hFF -> misaligned = 1.
- Registers:
  - Assert rst_n low mid-run -> pc_q = 0 and taken_q = 0 without a clock edge.
  - Release, then one rising edge -> pc_q equals the current pc.
